// File: rtl/gerenciador_estabelecidos_mp.sv
// gerenciador_estabelecidos_mp: established-node bitmap with multi-port set, combinational reads
// and a word-by-word clear sweep.
module gerenciador_estabelecidos_mp #(
    parameter int ADDR_WIDTH      = 8,
    parameter int NUM_WRITE_PORTS = 2,
    parameter int NUM_READ_PORTS  = 8,
    parameter int WORD_WIDTH      = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  soft_reset_n,
    input  logic [NUM_WRITE_PORTS-1:0]            write_en_in,
    input  logic [ADDR_WIDTH*NUM_WRITE_PORTS-1:0] write_addr_in,
    input  logic [ADDR_WIDTH*NUM_READ_PORTS-1:0]  read_addr_in,
    output logic [NUM_READ_PORTS-1:0]             read_data_out,
    output logic                                  busy_out,
    output logic [ADDR_WIDTH:0]                   settled_count_out,
    output logic                                  all_settled_out,
    output logic                                  write_drop_out
);
    localparam int N  = 2**ADDR_WIDTH;
    localparam int NW = N / WORD_WIDTH;
    localparam int PW = NW > 1 ? $clog2(NW) : 1;
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                r_state, w_state_nx;
    logic [PW-1:0]         r_ptr, w_ptr_nx;
    logic [N-1:0]          r_mem;
    logic [CW-1:0]         r_count;
    logic                  r_all, r_drop;
    logic [N-1:0]          w_set, w_clr_mask;
    logic [CW-1:0]         w_inc, w_cnt_nx;
    logic [CW:0]           w_sum;
    logic                  w_dup, w_wr_ok;
    logic [ADDR_WIDTH-1:0] w_waddr [NUM_WRITE_PORTS];

    for (genvar k = 0; k < NUM_WRITE_PORTS; k++) begin : g_wa
        assign w_waddr[k] = write_addr_in[ADDR_WIDTH*k +: ADDR_WIDTH];
    end

    for (genvar i = 0; i < NUM_READ_PORTS; i++) begin : g_rd
        assign read_data_out[i] = !busy_out && r_mem[read_addr_in[ADDR_WIDTH*i +: ADDR_WIDTH]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        if (r_state == IDLE) begin
            if (!soft_reset_n) begin
                w_state_nx = CLEAR;
                w_ptr_nx   = '0;
            end
        end else if (r_ptr == PW'(NW-1)) begin
            w_state_nx = soft_reset_n ? IDLE : CLEAR;
            w_ptr_nx   = '0;
        end else begin
            w_ptr_nx = r_ptr + PW'(1);
        end
    end

    always_comb begin
        busy_out = (r_state == CLEAR);
        w_wr_ok  = !busy_out && soft_reset_n;
    end

    // A port only counts if no lower-numbered enabled port already targets the same node.
    always_comb begin
        w_set = '0;
        w_inc = '0;
        w_dup = 1'b0;
        for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
            w_dup = 1'b0;
            for (int j = 0; j < k; j++)
                w_dup = w_dup | (write_en_in[j] && (w_waddr[j] == w_waddr[k]));
            if (write_en_in[k])
                w_set[w_waddr[k]] = 1'b1;
            if (write_en_in[k] && !w_dup && !r_mem[w_waddr[k]])
                w_inc = w_inc + CW'(1);
        end
    end

    always_comb begin
        w_clr_mask = '0;
        for (int w = 0; w < NW; w++)
            if (r_ptr == PW'(w))
                w_clr_mask[w*WORD_WIDTH +: WORD_WIDTH] = '1;
    end

    assign w_sum    = {1'b0, r_count} + {1'b0, w_inc};
    assign w_cnt_nx = (w_sum > (CW+1)'(N)) ? CW'(N) : w_sum[CW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem   <= '0;
            r_count <= '0;
            r_all   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            if (busy_out)
                r_mem <= r_mem & ~w_clr_mask;
            else if (w_wr_ok)
                r_mem <= r_mem | w_set;
            r_count <= w_wr_ok ? w_cnt_nx : '0;
            r_all   <= w_wr_ok && (w_cnt_nx == CW'(N));
            r_drop  <= (|write_en_in) && !w_wr_ok;
        end
    end

    assign settled_count_out = r_count;
    assign all_settled_out   = r_all;
    assign write_drop_out    = r_drop;
endmodule
